lz_normalizer: RTL and testbench

//  Iterative left-normalizer for the integer ALU. Consumes a 32-bit operand and shifts it

---
 rtl/lz_normalizer_if.sv | 26 ++
 rtl/lz_normalizer.sv | 121 ++++++++++++
 tb/tb_lz_normalizer.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/lz_normalizer_if.sv
// Operand/result handshake bundle for the iterative leading-zero normalizer.
// The design side uses the slave modport; the producer/consumer side uses master.
interface lz_normalizer_if;
    localparam int unsigned WIDTH = 32;
    localparam int unsigned IDX_W = 5;

    logic             valid_i;
    logic             ready_o;
    logic [WIDTH-1:0] data_i;
    logic             flush_i;
    logic             valid_o;
    logic             ready_i;
    logic [WIDTH-1:0] data_o;
    logic [IDX_W-1:0] index_o;
    logic             zero_o;

    modport slave (
        input  valid_i, data_i, flush_i, ready_i,
        output ready_o, valid_o, data_o, index_o, zero_o
    );

    modport master (
        output valid_i, data_i, flush_i, ready_i,
        input  ready_o, valid_o, data_o, index_o, zero_o
    );
endinterface

// File: rtl/lz_normalizer.sv
// Iterative left-normalizer: shifts an operand left until its MSB is set, STEP bits
// per cycle plus one final sub-step, reporting the leading-zero count and a zero flag.
module lz_normalizer #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned STEP  = 4
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    lz_normalizer_if.slave    bus
);
    localparam int unsigned IDX_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   work_q,  work_d;
    logic [IDX_W-1:0]   cnt_q,   cnt_d;
    logic [WIDTH-1:0]   data_q,  data_d;
    logic [IDX_W-1:0]   index_q, index_d;
    logic               zero_q,  zero_d;
    logic               ready_q, ready_d;
    logic               valid_q, valid_d;

    logic [STEP-1:0]    top_nib;
    logic [IDX_W-1:0]   fine_n;
    logic               found;

    // Leading zeros within the top STEP bits of the working register.
    always_comb begin
        top_nib = work_q[WIDTH-1 -: STEP];
        fine_n  = '0;
        found   = 1'b0;
        for (int i = STEP - 1; i >= 0; i--) begin
            if (!found) begin
                if (top_nib[i]) found  = 1'b1;
                else            fine_n = fine_n + IDX_W'(1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        index_d = index_q;
        zero_d  = zero_q;

        // Flush wins over any accept or output handshake on the same edge.
        if (bus.flush_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.valid_i && ready_q) begin
                        work_d = bus.data_i;
                        cnt_d  = '0;
                        if (bus.data_i == '0) begin
                            zero_d  = 1'b1;
                            data_d  = '0;
                            index_d = '0;
                            state_d = DONE;
                        end else begin
                            zero_d  = 1'b0;
                            state_d = SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    if (top_nib == '0) begin
                        work_d = work_q << STEP;
                        cnt_d  = cnt_q + IDX_W'(STEP);
                    end else begin
                        data_d  = work_q << fine_n;
                        index_d = cnt_q + fine_n;
                        state_d = DONE;
                    end
                end
                DONE: begin
                    if (valid_q && bus.ready_i) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end

        ready_d = (state_d == IDLE);
        valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            work_q  <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            index_q <= '0;
            zero_q  <= 1'b0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            index_q <= index_d;
            zero_q  <= zero_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
        end
    end

    assign bus.ready_o = ready_q;
    assign bus.valid_o = valid_q;
    assign bus.data_o  = data_q;
    assign bus.index_o = index_q;
    assign bus.zero_o  = zero_q;
endmodule

// File: tb/tb_lz_normalizer.sv
// Directed self-checking bench for lz_normalizer: latency, results, back-pressure,
// asynchronous reset and flush aborts.
module tb_lz_normalizer;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    lz_normalizer_if bif ();

    lz_normalizer #(.WIDTH(32), .STEP(4)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Present one operand, measure edges until valid_o and check the result.
    task automatic run_op(input string tag, input logic [31:0] d, input int exp_lat,
                          input logic [31:0] exp_data, input logic [4:0] exp_idx,
                          input logic exp_zero);
        int lat;
        @(negedge clk);
        check({tag, " ready before accept"}, 32'(bif.ready_o), 32'd1);
        bif.valid_i = 1'b1;
        bif.data_i  = d;
        @(posedge clk);
        #1;
        bif.valid_i = 1'b0;
        lat = 1;
        while (!bif.valid_o && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " data"},    bif.data_o, exp_data);
        check({tag, " index"},   32'(bif.index_o), 32'(exp_idx));
        check({tag, " zero"},    32'(bif.zero_o), 32'(exp_zero));
        if (bif.ready_i) begin
            @(posedge clk);
            #1;
            check({tag, " valid after handshake"}, 32'(bif.valid_o), 32'd0);
            check({tag, " ready after handshake"}, 32'(bif.ready_o), 32'd1);
        end
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        rst_n       = 1'b0;
        bif.valid_i = 1'b0;
        bif.data_i  = '0;
        bif.flush_i = 1'b0;
        bif.ready_i = 1'b1;

        #1;
        check("reset ready", 32'(bif.ready_o), 32'd0);
        check("reset valid", 32'(bif.valid_o), 32'd0);
        check("reset data",  bif.data_o, 32'd0);
        check("reset index", 32'(bif.index_o), 32'd0);
        check("reset zero",  32'(bif.zero_o), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("ready before first edge", 32'(bif.ready_o), 32'd0);
        @(posedge clk);
        #1;
        check("ready after release", 32'(bif.ready_o), 32'd1);

        run_op("msb set",  32'h8000_0000, 2, 32'h8000_0000, 5'd0,  1'b0);
        run_op("lsb only", 32'h0000_0001, 9, 32'h8000_0000, 5'd31, 1'b0);
        run_op("lz15",     32'h0001_2345, 5, 32'h91A2_8000, 5'd15, 1'b0);
        run_op("zero",     32'h0000_0000, 1, 32'h0000_0000, 5'd0,  1'b1);
        run_op("lz2",      32'h2000_0000, 2, 32'h8000_0000, 5'd2,  1'b0);

        // Back-pressure: result must hold while ready_i is low.
        bif.ready_i = 1'b0;
        run_op("bp", 32'h00F0_0000, 4, 32'hF000_0000, 5'd8, 1'b0);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            check("bp hold valid", 32'(bif.valid_o), 32'd1);
            check("bp hold data",  bif.data_o, 32'hF000_0000);
            check("bp hold index", 32'(bif.index_o), 32'd8);
            check("bp hold ready", 32'(bif.ready_o), 32'd0);
        end
        @(negedge clk);
        bif.ready_i = 1'b1;
        @(posedge clk);
        #1;
        check("bp release valid", 32'(bif.valid_o), 32'd0);
        check("bp release ready", 32'(bif.ready_o), 32'd1);

        // Asynchronous reset mid-SHIFT.
        @(negedge clk);
        bif.valid_i = 1'b1;
        bif.data_i  = 32'h0000_0001;
        @(posedge clk);
        #1;
        bif.valid_i = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort rst valid", 32'(bif.valid_o), 32'd0);
        check("abort rst ready", 32'(bif.ready_o), 32'd0);
        check("abort rst data",  bif.data_o, 32'd0);
        check("abort rst index", 32'(bif.index_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("abort rst ready after", 32'(bif.ready_o), 32'd1);

        // Flush mid-SHIFT.
        @(negedge clk);
        bif.valid_i = 1'b1;
        bif.data_i  = 32'h0000_0001;
        @(posedge clk);
        #1;
        bif.valid_i = 1'b0;
        check("flush in shift ready", 32'(bif.ready_o), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        bif.flush_i = 1'b1;
        @(posedge clk);
        #1;
        bif.flush_i = 1'b0;
        check("flush ready", 32'(bif.ready_o), 32'd1);
        check("flush valid", 32'(bif.valid_o), 32'd0);
        repeat (10) @(posedge clk);
        #1;
        check("flush no late valid", 32'(bif.valid_o), 32'd0);
        check("flush data untouched", bif.data_o, 32'd0);

        // Flush overrides a same-edge accept.
        @(negedge clk);
        bif.valid_i = 1'b1;
        bif.flush_i = 1'b1;
        bif.data_i  = 32'h0000_0010;
        @(posedge clk);
        #1;
        bif.valid_i = 1'b0;
        bif.flush_i = 1'b0;
        check("flush accept ready", 32'(bif.ready_o), 32'd1);
        repeat (4) @(posedge clk);
        #1;
        check("flush accept valid", 32'(bif.valid_o), 32'd0);

        run_op("post abort", 32'h4000_0000, 2, 32'h8000_0000, 5'd1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
